// File: rtl/stage_if_fetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
interface stage_if_fetch_if;
    logic        IMem_Req;
    logic [31:0] IMem_Addr;
    logic        IMem_Ack;
    logic [31:0] IMem_Data;

    // Fetch stage issues requests and receives instructions
    modport master (
        output IMem_Req,
        output IMem_Addr,
        input  IMem_Ack,
        input  IMem_Data
    );

    // Instruction memory answers requests
    modport slave (
        input  IMem_Req,
        input  IMem_Addr,
        output IMem_Ack,
        output IMem_Data
    );
endinterface

// File: rtl/stage_if_fetch.sv
// Instruction fetch stage plus IF/ID pipeline register for the pipelined MIPS.
// Owns the PC, talks to instruction memory over a req/ack bus, parks one
// instruction in a hold buffer while decode stalls, and applies jump/branch
// redirects by squashing IF/ID to a bubble.
module stage_if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic             Clk,
    input  logic             Rst_n,
    stage_if_fetch_if.master imem,
    input  logic             ID_Stall,
    input  logic             ID_Jump,
    input  logic [31:0]      ID_Jtarg,
    input  logic             EX_BrTaken,
    input  logic [31:0]      EX_BrTarg,
    output logic [31:0]      IFout_PC,
    output logic [31:0]      IFout_PC4,
    output logic [31:0]      IFout_Inst,
    output logic             IFout_Valid
);
    localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

    typedef enum logic {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t      r_state;
    logic        r_req;
    logic [31:0] r_pc;

    logic [31:0] r_hold_pc_p0;
    logic [31:0] r_hold_inst_p0;

    logic [31:0] r_ifid_pc_p1;
    logic [31:0] r_ifid_pc4_p1;
    logic [31:0] r_ifid_inst_p1;
    logic        r_ifid_vld_p1;

    logic        w_br_redir;
    logic        w_jmp_redir;
    logic        w_redir;
    logic [31:0] w_redir_pc;
    logic [31:0] w_pc_inc;
    logic [31:0] w_hold_pc_inc;

    // Older instruction (the branch in execute) wins; a stalled jump is not yet final.
    assign w_br_redir    = EX_BrTaken;
    assign w_jmp_redir   = ID_Jump & ~ID_Stall;
    assign w_redir       = w_br_redir | w_jmp_redir;
    assign w_redir_pc    = (w_br_redir ? EX_BrTarg : ID_Jtarg) & 32'hFFFF_FFFC;
    assign w_pc_inc      = r_pc + 32'd4;
    assign w_hold_pc_inc = r_hold_pc_p0 + 32'd4;

    assign imem.IMem_Req  = r_req & Rst_n;
    assign imem.IMem_Addr = r_pc;

    assign IFout_PC    = r_ifid_pc_p1;
    assign IFout_PC4   = r_ifid_pc4_p1;
    assign IFout_Inst  = r_ifid_inst_p1;
    assign IFout_Valid = r_ifid_vld_p1;

    // Fetch FSM: PC, hold buffer (p0) and IF/ID register (p1) update together.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_state        <= S_REQ;
            r_req          <= 1'b1;
            r_pc           <= RESET_PC_AL;
            r_hold_pc_p0   <= 32'h0;
            r_hold_inst_p0 <= NOP_INST;
            r_ifid_pc_p1   <= 32'h0;
            r_ifid_pc4_p1  <= 32'h0;
            r_ifid_inst_p1 <= NOP_INST;
            r_ifid_vld_p1  <= 1'b0;
        end else if (w_redir) begin
            // Abandon any outstanding fetch or held instruction; PC/PC4 keep their value.
            r_state        <= S_REQ;
            r_req          <= 1'b1;
            r_pc           <= w_redir_pc;
            r_ifid_inst_p1 <= NOP_INST;
            r_ifid_vld_p1  <= 1'b0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (imem.IMem_Ack) begin
                        r_pc <= w_pc_inc;
                        if (!ID_Stall) begin
                            r_ifid_pc_p1   <= r_pc;
                            r_ifid_pc4_p1  <= w_pc_inc;
                            r_ifid_inst_p1 <= imem.IMem_Data;
                            r_ifid_vld_p1  <= 1'b1;
                        end else begin
                            r_hold_pc_p0   <= r_pc;
                            r_hold_inst_p0 <= imem.IMem_Data;
                            r_state        <= S_HOLD;
                            r_req          <= 1'b0;
                        end
                    end else if (!ID_Stall) begin
                        r_ifid_inst_p1 <= NOP_INST;
                        r_ifid_vld_p1  <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!ID_Stall) begin
                        r_ifid_pc_p1   <= r_hold_pc_p0;
                        r_ifid_pc4_p1  <= w_hold_pc_inc;
                        r_ifid_inst_p1 <= r_hold_inst_p0;
                        r_ifid_vld_p1  <= 1'b1;
                        r_state        <= S_REQ;
                        r_req          <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_stage_if_fetch.sv
// Self-checking bench for stage_if_fetch: two instances (reset PC 0 and a
// wrap-around reset PC) share decode/execute stimulus, each with its own
// memory responder returning Data = Addr + 0x100.
module tb_stage_if_fetch;
    localparam logic [31:0] RST_A = 32'h0000_0000;
    localparam logic [31:0] RST_B = 32'hFFFF_FFF8;
    localparam logic [31:0] NOP   = 32'h0000_0000;

    logic        Clk;
    logic        Rst_n;
    logic        ID_Stall;
    logic        ID_Jump;
    logic [31:0] ID_Jtarg;
    logic        EX_BrTaken;
    logic [31:0] EX_BrTarg;

    logic [31:0] pc_a, pc4_a, inst_a, pc_b, pc4_b, inst_b;
    logic        v_a, v_b;

    stage_if_fetch_if bus_a ();
    stage_if_fetch_if bus_b ();

    int checks;
    int failures;
    int ack_delay;
    bit rand_mode;
    bit ack_rnd;
    int cnt_a;
    int cnt_b;

    stage_if_fetch #(.RESET_PC(RST_A), .NOP_INST(NOP)) dut_a (
        .Clk(Clk), .Rst_n(Rst_n), .imem(bus_a),
        .ID_Stall(ID_Stall), .ID_Jump(ID_Jump), .ID_Jtarg(ID_Jtarg),
        .EX_BrTaken(EX_BrTaken), .EX_BrTarg(EX_BrTarg),
        .IFout_PC(pc_a), .IFout_PC4(pc4_a), .IFout_Inst(inst_a), .IFout_Valid(v_a)
    );

    stage_if_fetch #(.RESET_PC(RST_B), .NOP_INST(NOP)) dut_b (
        .Clk(Clk), .Rst_n(Rst_n), .imem(bus_b),
        .ID_Stall(ID_Stall), .ID_Jump(ID_Jump), .ID_Jtarg(ID_Jtarg),
        .EX_BrTaken(EX_BrTaken), .EX_BrTarg(EX_BrTarg),
        .IFout_PC(pc_b), .IFout_PC4(pc4_b), .IFout_Inst(inst_b), .IFout_Valid(v_b)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Memory responders: ack after ack_delay waiting cycles, or randomly.
    assign bus_a.IMem_Ack  = bus_a.IMem_Req && (rand_mode ? ack_rnd : (cnt_a >= ack_delay));
    assign bus_a.IMem_Data = bus_a.IMem_Addr + 32'h100;
    assign bus_b.IMem_Ack  = bus_b.IMem_Req && (rand_mode ? ack_rnd : (cnt_b >= ack_delay));
    assign bus_b.IMem_Data = bus_b.IMem_Addr + 32'h100;

    always_ff @(posedge Clk) begin
        cnt_a <= (!Rst_n || !bus_a.IMem_Req || bus_a.IMem_Ack) ? 0 : cnt_a + 1;
        cnt_b <= (!Rst_n || !bus_b.IMem_Req || bus_b.IMem_Ack) ? 0 : cnt_b + 1;
    end

    // Reference model: architectural view of the fetch stage (PC, one optional
    // parked instruction, and the IF/ID contents).
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ifpc;
        logic [31:0] ifpc4;
        logic [31:0] ifinst;
        logic        ifv;
        logic        hv;
        logic [31:0] hpc;
        logic [31:0] hinst;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mstep(mdl_t m, logic [31:0] rpc, logic rst, logic br,
                                   logic [31:0] brt, logic jmp, logic [31:0] jt,
                                   logic stall, logic ack);
        mdl_t n = m;
        if (!rst) begin
            n.pc = rpc; n.ifpc = 32'h0; n.ifpc4 = 32'h0; n.ifinst = NOP; n.ifv = 1'b0; n.hv = 1'b0;
        end else if (br || (jmp && !stall)) begin
            n.pc = (br ? brt : jt) & 32'hFFFF_FFFC;
            n.ifinst = NOP; n.ifv = 1'b0; n.hv = 1'b0;
        end else if (m.hv) begin
            if (!stall) begin
                n.ifpc = m.hpc; n.ifpc4 = m.hpc + 32'd4; n.ifinst = m.hinst; n.ifv = 1'b1; n.hv = 1'b0;
            end
        end else if (ack) begin
            if (!stall) begin
                n.ifpc = m.pc; n.ifpc4 = m.pc + 32'd4; n.ifinst = m.pc + 32'h100; n.ifv = 1'b1;
            end else begin
                n.hv = 1'b1; n.hpc = m.pc; n.hinst = m.pc + 32'h100;
            end
            n.pc = m.pc + 32'd4;
        end else if (!stall) begin
            n.ifinst = NOP; n.ifv = 1'b0;
        end
        return n;
    endfunction

    function automatic logic [129:0] expv(mdl_t m, logic rst);
        return {m.ifpc, m.ifpc4, m.ifinst, m.ifv, (rst && !m.hv), m.pc};
    endfunction

    logic [129:0] obs_a, obs_b;
    assign obs_a = {pc_a, pc4_a, inst_a, v_a, bus_a.IMem_Req, bus_a.IMem_Addr};
    assign obs_b = {pc_b, pc4_b, inst_b, v_b, bus_b.IMem_Req, bus_b.IMem_Addr};

    // One clock: inputs were set at the falling edge; returns at the next falling edge.
    task automatic step();
        ack_rnd = 1'($urandom_range(0, 1));
        #1;
        ma = mstep(ma, RST_A, Rst_n, EX_BrTaken, EX_BrTarg, ID_Jump, ID_Jtarg, ID_Stall, bus_a.IMem_Ack);
        mb = mstep(mb, RST_B, Rst_n, EX_BrTaken, EX_BrTarg, ID_Jump, ID_Jtarg, ID_Stall, bus_b.IMem_Ack);
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic test_reset();
        Rst_n = 1'b0; ID_Stall = 1'b0; ID_Jump = 1'b0; ID_Jtarg = 32'h0;
        EX_BrTaken = 1'b0; EX_BrTarg = 32'h0; ack_delay = 0; rand_mode = 1'b0;
        repeat (3) begin
            step();
            checks++;
            if (obs_a !== expv(ma, Rst_n)) begin
                failures++; $display("FAIL reset_model got=%h exp=%h", obs_a, expv(ma, Rst_n));
            end
        end
        checks++;
        if ({pc_a, pc4_a, inst_a, v_a, bus_a.IMem_Req, bus_a.IMem_Addr} !== {32'h0, 32'h0, NOP, 1'b0, 1'b0, RST_A}) begin
            failures++; $display("FAIL reset_values got=%h", obs_a);
        end
        Rst_n = 1'b1;
        #1;
        checks++;
        if ({bus_a.IMem_Req, bus_a.IMem_Addr} !== {1'b1, RST_A}) begin
            failures++; $display("FAIL req_after_release got=%b/%h exp=1/%h", bus_a.IMem_Req, bus_a.IMem_Addr, RST_A);
        end
    endtask

    task automatic test_stream();
        for (int i = 1; i <= 8; i++) begin
            step();
            checks++;
            if ({v_a, pc_a, pc4_a, inst_a} !== {1'b1, 32'(4 * (i - 1)), 32'(4 * i), 32'(4 * (i - 1) + 256)}) begin
                failures++; $display("FAIL stream i=%0d got=%b %h %h %h exp pc=%h", i, v_a, pc_a, pc4_a, inst_a, 32'(4 * (i - 1)));
            end
            checks++;
            if (obs_a !== expv(ma, Rst_n)) begin
                failures++; $display("FAIL stream_model got=%h exp=%h", obs_a, expv(ma, Rst_n));
            end
        end
    endtask

    task automatic test_delayed_ack();
        logic [31:0] seen[$];
        ack_delay = 3;
        repeat (24) begin
            step();
            checks++;
            if (obs_a !== expv(ma, Rst_n)) begin
                failures++; $display("FAIL delay_model got=%h exp=%h", obs_a, expv(ma, Rst_n));
            end
            if (v_a) seen.push_back(pc_a);
        end
        checks++;
        if (seen.size() < 5 || seen.size() > 7) begin
            failures++; $display("FAIL delay_count got=%0d exp=5..7", seen.size());
        end
        for (int k = 1; k < seen.size(); k++) begin
            checks++;
            if (seen[k] !== seen[k - 1] + 32'd4) begin
                failures++; $display("FAIL delay_order k=%0d got=%h exp=%h", k, seen[k], seen[k - 1] + 32'd4);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] pre;
        logic [31:0] seen[$];
        ack_delay = 0;
        repeat (2) step();
        pre = ma.ifpc;
        ID_Stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({pc_a, inst_a, v_a, bus_a.IMem_Req, bus_a.IMem_Addr} !== {pre, pre + 32'h100, 1'b1, 1'b0, pre + 32'd8}) begin
                failures++; $display("FAIL stall_freeze i=%0d got=%h %h %b %b %h exp pc=%h", i, pc_a, inst_a, v_a, bus_a.IMem_Req, bus_a.IMem_Addr, pre);
            end
            checks++;
            if (obs_a !== expv(ma, Rst_n)) begin
                failures++; $display("FAIL stall_model got=%h exp=%h", obs_a, expv(ma, Rst_n));
            end
        end
        ID_Stall = 1'b0;
        repeat (4) begin
            step();
            seen.push_back(v_a ? pc_a : 32'hDEAD_BEEF);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (seen[k] !== pre + 32'(4 * (k + 1))) begin
                failures++; $display("FAIL stall_release k=%0d got=%h exp=%h", k, seen[k], pre + 32'(4 * (k + 1)));
            end
        end
    endtask

    task automatic test_jump();
        int n;
        Rst_n = 1'b0; step(); Rst_n = 1'b1;
        n = 0;
        while (ma.pc != 32'h8 && n < 10) begin step(); n++; end
        checks++;
        if (bus_a.IMem_Addr !== 32'h8) begin
            failures++; $display("FAIL jump_reach got=%h exp=00000008", bus_a.IMem_Addr);
        end
        ID_Jump = 1'b1; ID_Jtarg = 32'h0000_0040;
        step();
        ID_Jump = 1'b0;
        checks++;
        if ({bus_a.IMem_Addr, v_a, inst_a} !== {32'h40, 1'b0, NOP}) begin
            failures++; $display("FAIL jump_bubble got=%h %b %h exp=00000040 0 %h", bus_a.IMem_Addr, v_a, inst_a, NOP);
        end
        step();
        checks++;
        if ({pc_a, pc4_a, inst_a, v_a} !== {32'h40, 32'h44, 32'h140, 1'b1}) begin
            failures++; $display("FAIL jump_target got=%h %h %h %b exp=00000040", pc_a, pc4_a, inst_a, v_a);
        end
        ID_Stall = 1'b1; ID_Jump = 1'b1; ID_Jtarg = 32'h0000_0200;
        repeat (2) begin
            step();
            checks++;
            if (bus_a.IMem_Addr === 32'h200 || obs_a !== expv(ma, Rst_n)) begin
                failures++; $display("FAIL jump_stalled got=%h exp=%h", obs_a, expv(ma, Rst_n));
            end
        end
        ID_Jump = 1'b0; ID_Stall = 1'b0;
        step();
    endtask

    task automatic test_branch();
        bit saw40;
        ID_Stall = 1'b1; ID_Jump = 1'b1; ID_Jtarg = 32'h40;
        EX_BrTaken = 1'b1; EX_BrTarg = 32'h0000_0083;
        step();
        EX_BrTaken = 1'b0; ID_Jump = 1'b0; ID_Stall = 1'b0;
        checks++;
        if ({bus_a.IMem_Addr, bus_a.IMem_Req, v_a, inst_a} !== {32'h80, 1'b1, 1'b0, NOP}) begin
            failures++; $display("FAIL branch_redirect got=%h %b %b %h exp=00000080 1 0", bus_a.IMem_Addr, bus_a.IMem_Req, v_a, inst_a);
        end
        saw40 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus_a.IMem_Addr == 32'h40 || (v_a && pc_a == 32'h40)) saw40 = 1'b1;
            if (i == 0) begin
                checks++;
                if ({pc_a, v_a} !== {32'h80, 1'b1}) begin
                    failures++; $display("FAIL branch_target got=%h %b exp=00000080 1", pc_a, v_a);
                end
            end
            checks++;
            if (obs_a !== expv(ma, Rst_n)) begin
                failures++; $display("FAIL branch_model got=%h exp=%h", obs_a, expv(ma, Rst_n));
            end
        end
        checks++;
        if (saw40) begin
            failures++; $display("FAIL branch_no_jump got=1 exp=0");
        end
    endtask

    task automatic test_random();
        rand_mode = 1'b1;
        for (int i = 0; i < 400; i++) begin
            Rst_n      = ($urandom_range(0, 63) != 0);
            ID_Stall   = ($urandom_range(0, 2) == 0);
            ID_Jump    = ($urandom_range(0, 7) == 0);
            EX_BrTaken = ($urandom_range(0, 11) == 0);
            ID_Jtarg   = $urandom & 32'h0000_0FFF;
            EX_BrTarg  = $urandom & 32'h0000_0FFF;
            step();
            checks++;
            if (obs_a !== expv(ma, Rst_n)) begin
                failures++; $display("FAIL random i=%0d got=%h exp=%h", i, obs_a, expv(ma, Rst_n));
            end
        end
        rand_mode = 1'b0; Rst_n = 1'b1; ID_Stall = 1'b0; ID_Jump = 1'b0; EX_BrTaken = 1'b0;
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0000_0000;
        ack_delay = 0;
        Rst_n = 1'b0; step(); Rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({pc_b, pc4_b, inst_b, v_b} !== {exp_pc[i], exp_pc[i] + 32'd4, exp_pc[i] + 32'h100, 1'b1}) begin
                failures++; $display("FAIL wrap i=%0d got=%h %h %h %b exp=%h", i, pc_b, pc4_b, inst_b, v_b, exp_pc[i]);
            end
            checks++;
            if (obs_b !== expv(mb, Rst_n)) begin
                failures++; $display("FAIL wrap_model got=%h exp=%h", obs_b, expv(mb, Rst_n));
            end
        end
        checks++;
        if (bus_b.IMem_Addr !== 32'h4) begin
            failures++; $display("FAIL wrap_addr got=%h exp=00000004", bus_b.IMem_Addr);
        end
    endtask

    task automatic test_reset_mid_stall();
        ID_Stall = 1'b1;
        repeat (2) step();
        checks++;
        if ({bus_a.IMem_Req, bus_b.IMem_Req} !== 2'b00) begin
            failures++; $display("FAIL midstall_hold got=%b%b exp=00", bus_a.IMem_Req, bus_b.IMem_Req);
        end
        Rst_n = 1'b0;
        step();
        checks++;
        if (obs_a !== {32'h0, 32'h0, NOP, 1'b0, 1'b0, RST_A}) begin
            failures++; $display("FAIL midstall_reset_a got=%h", obs_a);
        end
        checks++;
        if (obs_b !== {32'h0, 32'h0, NOP, 1'b0, 1'b0, RST_B}) begin
            failures++; $display("FAIL midstall_reset_b got=%h", obs_b);
        end
        Rst_n = 1'b1; ID_Stall = 1'b0;
        repeat (2) begin
            step();
            checks++;
            if (obs_a !== expv(ma, Rst_n) || obs_b !== expv(mb, Rst_n)) begin
                failures++; $display("FAIL midstall_resume got=%h/%h exp=%h/%h", obs_a, obs_b, expv(ma, Rst_n), expv(mb, Rst_n));
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        ma = '0;
        mb = '0;
        test_reset();
        test_stream();
        test_delayed_ack();
        test_stall();
        test_jump();
        test_branch();
        test_random();
        test_wrap();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
